// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants, op encodings and FSM state type
// for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/response handshake bundle between the
// issuing pipeline (master) and the MDU (slave).
interface mdu_if;
    import mdu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic            resp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_result, resp_err
    );

endinterface

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-divide iteration
// (shift in next dividend bit, trial subtract, emit quotient bit).
module mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dbit,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_nxt,
    output logic            qbit
);

    logic [XLEN:0]   t;
    logic [XLEN-1:0] diff;

    // rem < dvs holds, so t - dvs always fits in XLEN bits
    assign t       = {rem, dbit};
    assign qbit    = t >= {1'b0, dvs};
    assign diff    = t[XLEN-1:0] - dvs;
    assign rem_nxt = qbit ? diff : t[XLEN-1:0];

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit, one step per cycle.
// Define MDU_DIV_EN to build the divider; otherwise div ops return err.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ITER_CYC = 32
) (
    input logic  clk,
    input logic  rst_n,
    input logic  flush,
    mdu_if.slave bus
);

    localparam logic [5:0]      LAST    = 6'(ITER_CYC);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [5:0]        cnt;
    logic [2:0]        op;
    logic [XLEN-1:0]   hi, lo, opb, res;
    logic              neg_q, err;
    logic              ready, accept, fast, fast_err;
    logic              a_sgn, b_sgn;
    logic [XLEN-1:0]   ma, mb, fast_res;
    logic [XLEN-1:0]   step_hi, step_lo, fin_res;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod;
`ifdef MDU_DIV_EN
    logic              neg_r, ovf, qbit;
    logic [XLEN-1:0]   rem_nxt;
`endif

    assign ready           = state == S_IDLE;
    assign accept          = ready && bus.req_valid && !flush;
    assign bus.req_ready   = ready;
    assign bus.resp_valid  = state == S_DONE;
    assign bus.resp_result = res;
    assign bus.resp_err    = err;

    always_comb begin
        a_sgn = bus.req_a[XLEN-1] &&
            (bus.req_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_sgn = bus.req_b[XLEN-1] &&
            (bus.req_op inside {OP_MULH, OP_DIV, OP_REM});
        ma = a_sgn ? -bus.req_a : bus.req_a;
        mb = b_sgn ? -bus.req_b : bus.req_b;
`ifdef MDU_DIV_EN
        ovf = (bus.req_op inside {OP_DIV, OP_REM}) &&
            bus.req_a == MIN_NEG && bus.req_b == '1;
        fast     = is_div(bus.req_op) && (bus.req_b == '0 || ovf);
        fast_err = 1'b0;
        if (bus.req_b == '0)
            fast_res = bus.req_op[1] ? bus.req_a : '1;
        else
            fast_res = bus.req_op[1] ? '0 : MIN_NEG;
`else
        fast     = is_div(bus.req_op);
        fast_err = 1'b1;
        fast_res = '0;
`endif
    end

`ifdef MDU_DIV_EN
    mdu_div_step #(.XLEN(XLEN)) u_step (
        .rem     (hi),
        .dbit    (lo[XLEN-1]),
        .dvs     (opb),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );
`endif

    // hi:lo is product (mul) or remainder:quotient (div)
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        step_hi = sum[XLEN:1];
        step_lo = {sum[0], lo[XLEN-1:1]};
        prod    = neg_q ? -{hi, lo} : {hi, lo};
        fin_res = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
        if (is_div(op)) begin
            step_hi = rem_nxt;
            step_lo = {lo[XLEN-2:0], qbit};
            fin_res = op[1] ? (neg_r ? -hi : hi) : (neg_q ? -lo : lo);
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (bus.req_valid) state_nxt = fast ? S_DONE : S_CALC;
                S_CALC:  if (cnt == LAST) state_nxt = S_DONE;
                S_DONE:  if (bus.resp_ready) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            op    <= '0;
            hi    <= '0;
            lo    <= '0;
            opb   <= '0;
            res   <= '0;
            err   <= 1'b0;
            neg_q <= 1'b0;
`ifdef MDU_DIV_EN
            neg_r <= 1'b0;
`endif
        end else if (accept) begin
            op    <= bus.req_op;
            cnt   <= '0;
            hi    <= '0;
            neg_q <= a_sgn ^ b_sgn;
`ifdef MDU_DIV_EN
            neg_r <= a_sgn;
`endif
            if (is_div(bus.req_op)) begin
                lo  <= ma;
                opb <= mb;
            end else begin
                lo  <= mb;
                opb <= ma;
            end
            if (fast) begin
                res <= fast_res;
                err <= fast_err;
            end
        end else if (state == S_CALC && !flush) begin
            if (cnt != LAST) begin
                cnt <= cnt + 6'd1;
                hi  <= step_hi;
                lo  <= step_lo;
            end else begin
                res <= fin_res;
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vectors with a response scoreboard for mdu_iter.
// Division expectations follow the MDU_DIV_EN build setting.
module tb_mdu_iter;
    import mdu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    logic flush = 0;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    exp_t sb[$];
    bit   last_v = 0;
    bit   seen = 0;

    mdu_if bus ();

    mdu_iter #(.XLEN(32), .ITER_CYC(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: compare every cycle the DUT presents a response
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            last_v = 0;
            seen   = 0;
        end else begin
            if (last_v && bus.resp_ready) begin
                if (sb.size() > 0) void'(sb.pop_front());
                seen = 0;
            end
            if (bus.resp_valid) begin
                if (sb.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL unexpected_resp: got result %h, none expected",
                             bus.resp_result);
                end else begin
                    if (!seen) check("latency", cyc - sb[0].acc, sb[0].lat);
                    check(seen ? "held_result" : "result",
                          bus.resp_result, sb[0].res);
                    check("err", {31'b0, bus.resp_err}, {31'b0, sb[0].err});
                    seen = 1;
                end
            end
            last_v = bus.resp_valid;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, b, res,
                         input logic err, input int lat, input bit push);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        if (push) sb.push_back('{res, err, lat, cyc + 1});
        @(negedge clk);
        bus.req_valid = 0;
        bus.req_op    = 3'($urandom);
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, b, res,
                       input logic err, input int lat);
        issue(op, a, b, res, err, lat, 1);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d errors so far", nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        bus.req_valid  = 0;
        bus.req_op     = 0;
        bus.req_a      = 0;
        bus.req_b      = 0;
        bus.resp_ready = 1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_result", bus.resp_result, 32'd0);
        check("rst_err", {31'b0, bus.resp_err}, 32'd0);
        rst_n = 1;

        run(OP_MUL,    32'd3,        32'd1,        32'h00000003, 0, 33);
        run(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 33);
        run(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 33);
        run(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 33);
        run(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0, 33);
        run(OP_MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 0, 33);
        run(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, 33);
        run(OP_MUL,    32'h12345678, 32'h10,       32'h23456780, 0, 33);
`ifdef MDU_DIV_EN
        run(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 33);
        run(OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 33);
        run(OP_DIVU, 32'd100,      32'd7,        32'd14,       0, 33);
        run(OP_REMU, 32'd100,      32'd7,        32'd2,        0, 33);
        run(OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 0);
        run(OP_REMU, 32'd5,        32'd0,        32'd5,        0, 0);
        run(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);
        run(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 0);
`else
        run(OP_DIVU, 32'd8,        32'd2,        32'd0,        1, 0);
        run(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'd0,        1, 0);
        run(OP_REMU, 32'd5,        32'd0,        32'd0,        1, 0);
        run(OP_MUL,  32'd9,        32'd9,        32'd81,       0, 33);
`endif

        // backpressure: response held in DONE
        bus.resp_ready = 0;
        issue(OP_MUL, 32'd6, 32'd7, 32'd42, 0, 33, 1);
        nv = 0;
        while (!bus.resp_valid && nv < 100) begin
            @(negedge clk);
            nv++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
            check("bp_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
            @(negedge clk);
        end
        bus.resp_ready = 1;
        drain();

        // flush on the 15th CALC cycle
        issue(OP_MUL, 32'd9, 32'd9, 32'd0, 0, 0, 0);
        repeat (14) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        check("flush_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("flush_req_ready", {31'b0, bus.req_ready}, 32'd1);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.resp_valid) nv++;
        end
        check("flush_no_resp", nv, 0);

        // asynchronous reset in the middle of CALC
        issue(OP_MUL, 32'd11, 32'd13, 32'd0, 0, 0, 0);
        repeat (10) @(negedge clk);
        rst_n = 0;
        #1;
        check("arst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("arst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("arst_result", bus.resp_result, 32'd0);
        @(negedge clk);
        rst_n = 1;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.resp_valid) nv++;
        end
        check("arst_no_resp", nv, 0);
        check("arst_idle_ready", {31'b0, bus.req_ready}, 32'd1);

        // request present at release is taken on the first edge
        rst_n = 0;
        @(negedge clk);
        rst_n         = 1;
        bus.req_valid = 1;
        bus.req_op    = OP_MUL;
        bus.req_a     = 32'd5;
        bus.req_b     = 32'd6;
        sb.push_back('{32'd30, 1'b0, 33, cyc + 1});
        @(negedge clk);
        bus.req_valid = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 Parameter ITER_CYC, default 32, iterations per multiply/divide; SHALL equal XLEN.
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 req_a  input  XLEN  operand rs1.
REQ-009 req_b  input  XLEN  operand rs2.
REQ-010 flush  input  1  synchronous abort of any in-flight operation.
REQ-011 resp_valid  output  1  result present.
REQ-012 resp_ready  input  1  consumer accepts result.
REQ-013 resp_result  output  XLEN  operation result.
REQ-014 resp_err  output  1  op not supported in this build.

Function
REQ-015 FSM states IDLE, CALC, DONE; req_ready SHALL be 1 only in IDLE.
REQ-016 Request accepted on the edge where req_valid and req_ready are both 1; operands and op registered, IDLE->CALC.
REQ-017 CALC: one shift-add (multiply) or restoring-subtract (divide) step per cycle on magnitudes; after ITER_CYC steps, CALC->DONE.
REQ-018 Normal latency: resp_valid asserted exactly ITER_CYC+1 cycles after the accepting edge.
REQ-019 Multiply: 64-bit product; MUL returns low 32 bits; MULH signed x signed high; MULHSU signed a x unsigned b high; MULHU unsigned high.
REQ-020 Signed ops: operate on magnitudes, negate result on completion per RISC-V sign rules (quotient sign = a^b, remainder sign = a).
REQ-021 Divide by zero: fast path, IDLE->DONE in one cycle; DIV/DIVU return 32'hFFFFFFFF, REM/REMU return req_a.
REQ-022 Signed overflow (a=32'h80000000, b=32'hFFFFFFFF): fast path one cycle; DIV returns 32'h80000000, REM returns 0.
REQ-023 DONE: resp_valid=1, resp_result/resp_err held stable until resp_valid&&resp_ready, then DONE->IDLE.
REQ-024 No new request accepted in the same cycle the response is consumed; next acceptance earliest one cycle later.
REQ-025 flush=1 in any state: next state IDLE, resp_valid=0, pending result discarded; flush dominates req_valid and resp_ready in the same cycle.
REQ-026 Inputs req_a/req_b/req_op ignored while req_ready=0.

Reset
REQ-027 rst_n low: state IDLE, req_ready=1, resp_valid=0, resp_result=0, resp_err=0, all datapath registers 0, immediately and asynchronously.
REQ-028 Reset during CALC or DONE SHALL discard the operation with no response issued.
REQ-029 Deassertion is synchronised to clk in the system; unit accepts a request on the first edge after release.

Configuration
REQ-030 Macro MDU_DIV_EN defined: all eight ops implemented as above.
REQ-031 MDU_DIV_EN undefined: divider datapath absent; ops 100-111 go IDLE->DONE in one cycle with resp_result=0, resp_err=1; multiply ops unaffected.

Structure
REQ-032 Shared package mdu_pkg SHALL hold XLEN, the op encoding constants, and the FSM state enum.
REQ-033 Sub-module mdu_div_step: one combinational restoring-divide iteration (partial remainder, quotient bit), instantiated only under MDU_DIV_EN.

Verification
REQ-034 MUL a=3, b=1 after reset -> resp_valid at accept+33, resp_result=32'h00000003, resp_err=0.
REQ-035 MULH a=32'hFFFFFFFF (-1), b=32'hFFFFFFFF -> result 32'h00000000; MULHU same operands -> 32'hFFFFFFFE.
REQ-036 DIV a=32'hFFFFFFF9 (-7), b=2 -> 32'hFFFFFFFD; REM same -> 32'hFFFFFFFF; DIVU a=5, b=0 -> 32'hFFFFFFFF one cycle after accept.
REQ-037 DIV a=32'h80000000, b=32'hFFFFFFFF -> 32'h80000000 one cycle after accept; REM -> 0.
REQ-038 Backpressure: resp_ready=0 for 10 cycles in DONE -> result stable, req_ready=0 throughout; then flush at cycle 15 of a new CALC -> IDLE next cycle, no resp_valid.
REQ-039 Build without MDU_DIV_EN: DIVU a=8, b=2 -> resp_err=1, resp_result=0 one cycle after accept; rst_n pulsed mid-CALC -> resp_valid stays 0, req_ready=1.
